// File: rtl/junction_scheduler.sv
// Purpose: two-approach junction sequencer (A main, B side) with a shared pedestrian walk phase.
// Latency: lamps are registered from the next-state decode, so they change on the same edge as the state.
// Backpressure: none; sensors are sampled only at decision edges, and a button press is latched until served.
//
// Ports:
//   clk_i                            system clock
//   rst_ni                           synchronous active-low reset (aborts any phase, drops pending walk)
//   req_a_i / req_b_i                vehicle sensor levels for approach A / B (already synchronised)
//   ped_button_i                     pedestrian button; any high cycle outside WALK latches a request
//   a_red_o a_amber_o a_green_o      approach A lamp lines
//   b_red_o b_amber_o b_green_o      approach B lamp lines
//   walk_o                           pedestrian walk lamp
module junction_scheduler #(
    parameter int GREEN_MIN   = 6,
    parameter int GREEN_MAX   = 12,
    parameter int AMBER_T     = 2,
    parameter int RED_AMBER_T = 2,
    parameter int ALL_RED_T   = 2,
    parameter int WALK_T      = 7,
    parameter int CNT_W       = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic req_a_i,
    input  logic req_b_i,
    input  logic ped_button_i,
    output logic a_red_o,
    output logic a_amber_o,
    output logic a_green_o,
    output logic b_red_o,
    output logic b_amber_o,
    output logic b_green_o,
    output logic walk_o
);

    typedef enum logic [2:0] {
        ST_ALL_RED     = 3'd0,
        ST_A_RED_AMBER = 3'd1,
        ST_A_GREEN     = 3'd2,
        ST_A_AMBER     = 3'd3,
        ST_B_RED_AMBER = 3'd4,
        ST_B_GREEN     = 3'd5,
        ST_B_AMBER     = 3'd6,
        ST_WALK        = 3'd7
    } state_t;

    typedef struct packed {
        logic a_red;
        logic a_amber;
        logic a_green;
        logic b_red;
        logic b_amber;
        logic b_green;
        logic walk;
    } lamp_t;

    // Last count value of each timed phase; the phase leaves at the end of that cycle.
    localparam logic [CNT_W-1:0] GMIN_END      = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] GMAX_END      = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] AMBER_END     = CNT_W'(AMBER_T - 1);
    localparam logic [CNT_W-1:0] RED_AMBER_END = CNT_W'(RED_AMBER_T - 1);
    localparam logic [CNT_W-1:0] ALL_RED_END   = CNT_W'(ALL_RED_T - 1);
    localparam logic [CNT_W-1:0] WALK_END      = CNT_W'(WALK_T - 1);
    localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);

    state_t           state_q;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_nxt;
    logic             ped_pend_q;
    logic             ped_pend_nxt;
    logic             last_a_q;      // 1: A was the most recent green, 0: B
    logic             last_a_nxt;
    lamp_t            lamp_q;

    logic             a_green_exit;
    logic             b_green_exit;
    logic             in_green;
    logic             state_change;

    // Lamp pattern for a state. Both heads default to red so any state not
    // explicitly granting an approach keeps it stopped.
    function automatic lamp_t lamp_decode(input state_t s);
        lamp_t l;
        l       = '0;
        l.a_red = 1'b1;
        l.b_red = 1'b1;
        case (s)
            ST_A_RED_AMBER: l.a_amber = 1'b1;
            ST_A_GREEN: begin
                l.a_red   = 1'b0;
                l.a_green = 1'b1;
            end
            ST_A_AMBER: begin
                l.a_red   = 1'b0;
                l.a_amber = 1'b1;
            end
            ST_B_RED_AMBER: l.b_amber = 1'b1;
            ST_B_GREEN: begin
                l.b_red   = 1'b0;
                l.b_green = 1'b1;
            end
            ST_B_AMBER: begin
                l.b_red   = 1'b0;
                l.b_amber = 1'b1;
            end
            ST_WALK: l.walk = 1'b1;
            default: l.walk = 1'b0;
        endcase
        return l;
    endfunction

    // A green may only end once the minimum has been served and something
    // else wants the junction; it then ends on a traffic gap or at the max.
    // The max compare relies on cnt saturating at GMAX_END while green.
    assign a_green_exit = (cnt_q >= GMIN_END) && (req_b_i || ped_pend_q)
                          && (!req_a_i || (cnt_q == GMAX_END));
    assign b_green_exit = (cnt_q >= GMIN_END) && (req_a_i || ped_pend_q)
                          && (!req_b_i || (cnt_q == GMAX_END));

    assign in_green     = (state_q == ST_A_GREEN) || (state_q == ST_B_GREEN);
    assign state_change = (state_nxt != state_q);

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_ALL_RED: begin
                if (cnt_q == ALL_RED_END) begin
                    // Walk first, then the approach opposite the last green
                    // when it asks, then whoever asks, else rest on main.
                    if (ped_pend_q) begin
                        state_nxt = ST_WALK;
                    end else if (last_a_q && req_b_i) begin
                        state_nxt = ST_B_RED_AMBER;
                    end else if (!last_a_q && req_a_i) begin
                        state_nxt = ST_A_RED_AMBER;
                    end else if (req_a_i) begin
                        state_nxt = ST_A_RED_AMBER;
                    end else if (req_b_i) begin
                        state_nxt = ST_B_RED_AMBER;
                    end else begin
                        state_nxt = ST_A_RED_AMBER;
                    end
                end
            end
            ST_A_RED_AMBER: begin
                if (cnt_q == RED_AMBER_END) state_nxt = ST_A_GREEN;
            end
            ST_A_GREEN: begin
                if (a_green_exit) state_nxt = ST_A_AMBER;
            end
            ST_A_AMBER: begin
                if (cnt_q == AMBER_END) state_nxt = ST_ALL_RED;
            end
            ST_B_RED_AMBER: begin
                if (cnt_q == RED_AMBER_END) state_nxt = ST_B_GREEN;
            end
            ST_B_GREEN: begin
                if (b_green_exit) state_nxt = ST_B_AMBER;
            end
            ST_B_AMBER: begin
                if (cnt_q == AMBER_END) state_nxt = ST_ALL_RED;
            end
            ST_WALK: begin
                if (cnt_q == WALK_END) state_nxt = ST_ALL_RED;
            end
            default: state_nxt = ST_ALL_RED;
        endcase
    end

    always_comb begin
        // Greens hold the count at the max so a long rest never wraps it;
        // every other phase leaves before reaching its own wrap point.
        if (state_change) begin
            cnt_nxt = '0;
        end else if (in_green && (cnt_q == GMAX_END)) begin
            cnt_nxt = cnt_q;
        end else begin
            cnt_nxt = cnt_q + CNT_ONE;
        end

        // Entering WALK serves the request; a press landing on that same
        // edge is covered by the walk about to start.
        ped_pend_nxt = ped_pend_q;
        if (state_change && (state_nxt == ST_WALK)) begin
            ped_pend_nxt = 1'b0;
        end else if (ped_button_i && (state_q != ST_WALK)) begin
            ped_pend_nxt = 1'b1;
        end

        // Only green entries move the alternation pointer; WALK leaves it.
        last_a_nxt = last_a_q;
        if (state_change && (state_nxt == ST_A_GREEN)) begin
            last_a_nxt = 1'b1;
        end else if (state_change && (state_nxt == ST_B_GREEN)) begin
            last_a_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= ST_ALL_RED;
            cnt_q      <= '0;
            ped_pend_q <= 1'b0;
            last_a_q   <= 1'b0;
            lamp_q     <= lamp_decode(ST_ALL_RED);
        end else begin
            state_q    <= state_nxt;
            cnt_q      <= cnt_nxt;
            ped_pend_q <= ped_pend_nxt;
            last_a_q   <= last_a_nxt;
            // Lamps are flopped from the next state so they always equal the
            // decode of state_q, without decode glitches on the lamp lines.
            lamp_q     <= lamp_decode(state_nxt);
        end
    end

    assign a_red_o   = lamp_q.a_red;
    assign a_amber_o = lamp_q.a_amber;
    assign a_green_o = lamp_q.a_green;
    assign b_red_o   = lamp_q.b_red;
    assign b_amber_o = lamp_q.b_amber;
    assign b_green_o = lamp_q.b_green;
    assign walk_o    = lamp_q.walk;

endmodule

// File: tb/tb_junction_scheduler.sv
module tb_junction_scheduler;

    localparam int GREEN_MIN   = 6;
    localparam int GREEN_MAX   = 12;
    localparam int AMBER_T     = 2;
    localparam int RED_AMBER_T = 2;
    localparam int ALL_RED_T   = 2;
    localparam int WALK_T      = 7;
    localparam int CNT_W       = 8;

    // Model phase codes (bench-local numbering).
    localparam int M_AR   = 0;
    localparam int M_ARA  = 1;
    localparam int M_AG   = 2;
    localparam int M_AA   = 3;
    localparam int M_BRA  = 4;
    localparam int M_BG   = 5;
    localparam int M_BA   = 6;
    localparam int M_WALK = 7;

    logic clk = 1'b0;
    logic rst_n;
    logic req_a;
    logic req_b;
    logic ped;
    logic a_red_o, a_amber_o, a_green_o;
    logic b_red_o, b_amber_o, b_green_o;
    logic walk_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    junction_scheduler #(
        .GREEN_MIN  (GREEN_MIN),
        .GREEN_MAX  (GREEN_MAX),
        .AMBER_T    (AMBER_T),
        .RED_AMBER_T(RED_AMBER_T),
        .ALL_RED_T  (ALL_RED_T),
        .WALK_T     (WALK_T),
        .CNT_W      (CNT_W)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_a_i     (req_a),
        .req_b_i     (req_b),
        .ped_button_i(ped),
        .a_red_o     (a_red_o),
        .a_amber_o   (a_amber_o),
        .a_green_o   (a_green_o),
        .b_red_o     (b_red_o),
        .b_amber_o   (b_amber_o),
        .b_green_o   (b_green_o),
        .walk_o      (walk_o)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Phase plus cycles already spent in it; a phase of length T is left once
    // T cycles have been served. Green time is not capped here: "served at
    // least GREEN_MAX" expresses the max-out directly.
    int m_phase;
    int m_elapsed;
    bit m_ped;
    bit m_last_a;
    bit m_ok = 1'b0;
    int m_nxt;
    int m_served;

    function automatic logic [6:0] lamps_of(input int p);
        logic [2:0] a;
        logic [2:0] b;
        a = 3'b100;
        b = 3'b100;
        if (p == M_ARA) a = 3'b110;
        if (p == M_AG)  a = 3'b001;
        if (p == M_AA)  a = 3'b010;
        if (p == M_BRA) b = 3'b110;
        if (p == M_BG)  b = 3'b001;
        if (p == M_BA)  b = 3'b010;
        return {a, b, (p == M_WALK)};
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_phase   = M_AR;
            m_elapsed = 0;
            m_ped     = 1'b0;
            m_last_a  = 1'b0;
            m_ok      = 1'b1;
        end else if (m_ok) begin
            m_served = m_elapsed + 1;
            m_nxt    = m_phase;
            case (m_phase)
                M_AR: if (m_served >= ALL_RED_T) begin
                    if (m_ped)                   m_nxt = M_WALK;
                    else if (m_last_a && req_b)  m_nxt = M_BRA;
                    else if (!m_last_a && req_a) m_nxt = M_ARA;
                    else if (req_a)              m_nxt = M_ARA;
                    else if (req_b)              m_nxt = M_BRA;
                    else                         m_nxt = M_ARA;
                end
                M_ARA: if (m_served >= RED_AMBER_T) m_nxt = M_AG;
                M_AG: if ((req_b || m_ped) && m_served >= GREEN_MIN
                          && (!req_a || m_served >= GREEN_MAX)) m_nxt = M_AA;
                M_AA: if (m_served >= AMBER_T) m_nxt = M_AR;
                M_BRA: if (m_served >= RED_AMBER_T) m_nxt = M_BG;
                M_BG: if ((req_a || m_ped) && m_served >= GREEN_MIN
                          && (!req_b || m_served >= GREEN_MAX)) m_nxt = M_BA;
                M_BA: if (m_served >= AMBER_T) m_nxt = M_AR;
                M_WALK: if (m_served >= WALK_T) m_nxt = M_AR;
                default: m_nxt = M_AR;
            endcase
            if (m_phase != M_WALK && ped) m_ped = 1'b1;
            if (m_nxt == M_WALK && m_phase != M_WALK) m_ped = 1'b0;
            if (m_nxt == M_AG && m_phase != M_AG) m_last_a = 1'b1;
            if (m_nxt == M_BG && m_phase != M_BG) m_last_a = 1'b0;
            m_elapsed = (m_nxt != m_phase) ? 0 : m_elapsed + 1;
            m_phase   = m_nxt;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_ok) begin
            check("lamps_vs_model",
                  {a_red_o, a_amber_o, a_green_o, b_red_o, b_amber_o, b_green_o, walk_o},
                  lamps_of(m_phase));
            check("no_dual_green", a_green_o & b_green_o, 0);
        end
    end

    // ---------------- directed helpers ----------------
    task automatic wait_green(input bit is_a, input int limit, output int n);
        n = 0;
        while (n < limit) begin
            @(negedge clk);
            n++;
            if (is_a ? a_green_o : b_green_o) return;
        end
        checks++;
        errors++;
        $display("FAIL wait_green timeout approach_a=%0d after %0d cycles", is_a, n);
        n = -1;
    endtask

    // Counts consecutive green cycles, the current negedge included.
    task automatic green_len(input bit is_a, output int n);
        n = 1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (is_a ? a_green_o : b_green_o) n++;
            else break;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("reset_lamps",
              {a_red_o, a_amber_o, a_green_o, b_red_o, b_amber_o, b_green_o, walk_o},
              7'b100_100_0);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        rst_n = 1'b0;
        req_a = 1'b0;
        req_b = 1'b0;
        ped   = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_lamps",
              {a_red_o, a_amber_o, a_green_o, b_red_o, b_amber_o, b_green_o, walk_o},
              7'b100_100_0);
        rst_n = 1'b1;

        // 1: idle junction rests on main after all-red 2 + red-amber 2.
        wait_green(1'b1, 20, n);
        check("t1_cycles_to_a_green", n, 4);
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            check("t1_rest_on_a", {a_green_o, b_red_o, walk_o}, 3'b110);
        end

        // 2: continuous A traffic, B arrives at green cycle 3 -> max-out at 12.
        req_a = 1'b1;
        do_reset();
        wait_green(1'b1, 20, n);
        check("t2_cycles_to_a_green", n, 4);
        n = 1;
        repeat (3) begin
            @(negedge clk);
            n++;
        end
        req_b = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (a_green_o) n++;
            else break;
        end
        check("t2_a_green_len", n, 12);
        check("t2_a_amber_after", {a_amber_o, a_green_o, b_red_o}, 3'b101);
        // amber 1 more + all-red 2 + red-amber 2 + first green cycle
        wait_green(1'b0, 20, n);
        check("t2_amber_to_b_green", n, 6);

        // 3: gap-out: A idle, B waiting -> A green lasts GREEN_MIN.
        req_a = 1'b0;
        req_b = 1'b0;
        do_reset();
        wait_green(1'b1, 20, n);
        req_b = 1'b1;
        green_len(1'b1, n);
        check("t3_gap_out_len", n, 6);
        wait_green(1'b0, 20, n);
        check("t3_amber_to_b_green", n, 6);

        // 4: button pulse during B green with B idle -> walk 7, press in walk ignored.
        req_b = 1'b0;
        ped   = 1'b1;
        n     = 1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            ped = 1'b0;
            if (b_green_o) n++;
            else break;
        end
        check("t4_b_green_len", n, 6);
        n = 0;
        while (n < 20 && !walk_o) begin
            @(negedge clk);
            n++;
        end
        check("t4_amber_to_walk", n, 4);
        check("t4_walk_all_red", {a_red_o, b_red_o, a_green_o, b_green_o, walk_o}, 5'b11001);
        n = 1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (walk_o) n++;
            else break;
            ped = (n == 3);
        end
        ped = 1'b0;
        check("t4_walk_len", n, 7);
        wait_green(1'b1, 20, n);
        check("t4_walk_to_a_green", n, 4);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("t4_no_second_walk", {walk_o, a_green_o}, 2'b01);
        end

        // 5: both approaches saturated -> strict alternation, 12 each.
        req_a = 1'b1;
        req_b = 1'b1;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            wait_green((i % 2) == 0, 30, n);
            green_len((i % 2) == 0, n);
            check((i % 2) == 0 ? "t5_a_green_len" : "t5_b_green_len", n, 12);
        end

        // 6: reset mid A green with a walk pending -> request is lost.
        req_b = 1'b0;
        wait_green(1'b1, 30, n);
        ped = 1'b1;
        @(negedge clk);
        ped = 1'b0;
        @(negedge clk);
        do_reset();
        wait_green(1'b1, 20, n);
        check("t6_restart_to_a_green", n, 4);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("t6_pending_walk_dropped", {walk_o, a_green_o}, 2'b01);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/junction_scheduler.md
# junction_scheduler

Two-approach junction controller that sequences the main-road (A) and side-road (B) signal heads and a shared pedestrian crossing. It arbitrates right-of-way between vehicle sensor requests and latched pedestrian requests. It guarantees an amber, all-red and red-amber clearance between conflicting greens, and bounds every green between a minimum and a maximum dwell. It sits above the per-head lamp drivers and drives their lamp lines directly.

## Interface
- GREEN_MIN, default 6: minimum green dwell, in cycles (≥1).
- GREEN_MAX, default 12: maximum green dwell while a conflicting request exists (≥ GREEN_MIN).
- AMBER_T, default 2: amber dwell, in cycles (≥1).
- RED_AMBER_T, default 2: red-amber dwell, in cycles (≥1).
- ALL_RED_T, default 2: all-red clearance dwell, in cycles (≥1).
- WALK_T, default 7: pedestrian walk dwell, in cycles (≥1).
- CNT_W, default 8: dwell counter width; every timing parameter must be ≤ 2^CNT_W.
- clk_i  in  1  system clock; the only clock.
- rst_ni  in  1  synchronous, active-low reset.
- req_a_i  in  1  approach A vehicle sensor; level, not latched.
- req_b_i  in  1  approach B vehicle sensor; level, not latched.
- ped_button_i  in  1  pedestrian button; any high cycle registers a request.
- a_red_o, a_amber_o, a_green_o  out  1 each  approach A lamps.
- b_red_o, b_amber_o, b_green_o  out  1 each  approach B lamps.
- walk_o  out  1  pedestrian walk lamp.

## Operation
- States: ALL_RED, A_RED_AMBER, A_GREEN, A_AMBER, B_RED_AMBER, B_GREEN, B_AMBER, WALK.
- Outputs are a Moore decode of the state register. No glitches are allowed, and no two conflicting greens may ever be active.
  - A lamps: red in every state except A_RED_AMBER/A_GREEN/A_AMBER. A_RED_AMBER = red+amber, A_GREEN = green, A_AMBER = amber. B lamps follow the same rules.
  - walk_o = 1 only in WALK; both heads show red in WALK.
- Dwell counter `cnt`: cleared on every state entry, +1 per cycle. A timed state of length T exits at the end of the cycle where cnt == T-1.
- Timed exits:
  - A_RED_AMBER and B_RED_AMBER → own GREEN.
  - A_AMBER, B_AMBER and WALK → ALL_RED.
- A_GREEN (B_GREEN symmetric):
  - conflict = req_b_i | ped_pend.
  - Exit to A_AMBER at the end of a cycle with cnt ≥ GREEN_MIN-1 and conflict, and either !req_a_i (gap-out) or cnt == GREEN_MAX-1 (max-out).
  - Without a conflict, green holds indefinitely; cnt saturates at GREEN_MAX-1.
- ALL_RED decision, taken at cnt == ALL_RED_T-1, first match wins:
  1. ped_pend → WALK.
  2. last == A and req_b_i → B_RED_AMBER.
  3. last == B and req_a_i → A_RED_AMBER.
  4. req_a_i → A_RED_AMBER.
  5. req_b_i → B_RED_AMBER.
  6. Otherwise → A_RED_AMBER (rest on main).
- `last` records the most recent approach given green; it is updated on entry to X_GREEN. WALK does not change it.
- ped_pend:
  - Set on any cycle with ped_button_i = 1 and state ≠ WALK.
  - Cleared on entry to WALK.
  - Presses during WALK are ignored. The set is sticky until served.
- Reset (rst_ni = 0 at a clock edge): state = ALL_RED, cnt = 0, ped_pend = 0, last = B. Outputs in the next cycle: a_red_o = b_red_o = 1, all others 0. Reset mid-phase aborts immediately; no amber is owed.

## Timing
- Sensor inputs are sampled only at decision edges; there is no internal synchronizer (the caller provides one).
- Button-to-walk worst case from a green held by continuous traffic: (GREEN_MAX - elapsed) + AMBER_T + ALL_RED_T cycles. From ALL_RED, walk starts on the next state entry.
- Simultaneous button press and WALK exit: the press is ignored, because state == WALK on that cycle.
- Simultaneous req_a_i/req_b_i at a decision: alternation via `last`. Starvation of either approach is impossible.
- Counter wrap is impossible because cnt saturates in green states and every other state exits at T-1.

## Test plan
- Reset, no requests: ALL_RED for 2 cycles → A_RED_AMBER for 2 → A_GREEN held for 50+ cycles. a_green_o = 1, b_red_o = 1, walk_o = 0 throughout the hold.
- Hold req_a_i = 1, assert req_b_i at cycle 3 of A_GREEN: A_GREEN lasts exactly GREEN_MAX = 12 cycles, then A_AMBER 2, ALL_RED 2, B_RED_AMBER 2, B_GREEN.
- req_a_i = 0 with req_b_i = 1 during A_GREEN: green ends after exactly GREEN_MIN = 6 cycles (gap-out).
- One-cycle ped_button_i pulse during B_GREEN with req_b_i = 0: B_AMBER → ALL_RED → WALK for exactly 7 cycles with all red → ALL_RED. A 1-cycle press during WALK does not cause a second WALK.
- req_a_i = req_b_i = 1 continuously: greens alternate A, B, A, B, each 12 cycles. No two green outputs are ever high together (assert every cycle).
- rst_ni low for 1 cycle mid-A_GREEN: the next cycle shows all red with walk_o = 0, and the sequence restarts as in test 1. A pending ped request is lost.
